// File: rtl/game_dialog_ctl.sv
// ----------------------------------------------------------------------------
// game_dialog_ctl
//
// Sequences the in-game dialog overlay. It watches the trigger zone under the
// player and the accept key. It selects which text block and page the renderer
// shows, drives the per-frame typewriter reveal count, and owns the sticky
// game-progress flags.
//
// Optional feature: define GAME_DIALOG_TYPEWRITER_EN to reveal text gradually
// on each frame tick. Without it, a page is shown in full one cycle after it
// is entered, and frame ticks are ignored.
//
// Ports
//   clk          pixel clock
//   rst          asynchronous active-high reset
//   key          current key code (level, 0 = none)
//   current_pix  zone code under the player: 2 NPC1, 3 NPC2, 4 door, 6 item
//   vblnk        vertical blank; its rising edge is the frame tick
//   dialog_sel   selected dialog: 0 none, 1 NPC1, 2 NPC2 pre-item,
//                3 NPC2 post-item, 4 door locked, 5 door open, 6 item
//   page         page index within the selected dialog
//   reveal_cnt   number of characters of the page the renderer may draw
//   dialog_on    overlay enable
//   item, item2, door  sticky progress flags, cleared only by reset
// ----------------------------------------------------------------------------
module game_dialog_ctl #(
    parameter logic [3:0]  KEY_ACCEPT      = 4'h1,
    parameter int unsigned PAGE_CHARS      = 128,
    parameter int unsigned CHARS_PER_FRAME = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key,
    input  logic [3:0] current_pix,
    input  logic       vblnk,
    output logic [2:0] dialog_sel,
    output logic [1:0] page,
    output logic [7:0] reveal_cnt,
    output logic       dialog_on,
    output logic       item,
    output logic       item2,
    output logic       door
);

    typedef enum logic [1:0] {StIdle, StType, StFull, StDone} state_e;

    localparam logic [3:0] ZoneNpc1 = 4'd2;
    localparam logic [3:0] ZoneNpc2 = 4'd3;
    localparam logic [3:0] ZoneDoor = 4'd4;
    localparam logic [3:0] ZoneItem = 4'd6;

    localparam logic [2:0] SelNone       = 3'd0;
    localparam logic [2:0] SelNpc1       = 3'd1;
    localparam logic [2:0] SelNpc2Pre    = 3'd2;
    localparam logic [2:0] SelNpc2Post   = 3'd3;
    localparam logic [2:0] SelDoorLocked = 3'd4;
    localparam logic [2:0] SelDoorOpen   = 3'd5;
    localparam logic [2:0] SelItem       = 3'd6;

    localparam logic [7:0] RevealFull = 8'(PAGE_CHARS);
    localparam logic [8:0] RevealFull9 = 9'(PAGE_CHARS);
    localparam logic [8:0] RevealStep9 = 9'(CHARS_PER_FRAME);

    state_e     state_q, state_d;
    logic [3:0] zone_q, zone_d;
    logic [3:0] key_q;
    logic       vblnk_q;
    logic [2:0] sel_q, sel_d;
    logic [1:0] page_q, page_d;
    logic [7:0] reveal_q, reveal_d;
    logic       on_q, on_d;
    logic       item_q, item_d;
    logic       item2_q, item2_d;
    logic       door_q, door_d;

    logic       key_press;
    logic       frame_tick;
    logic       zone_trigger;
    logic       zone_left;
    logic [1:0] last_page;
    logic [8:0] reveal_sum;

    // Edge detectors: a held key or a long vblank produces a single event.
    assign key_press  = (key == KEY_ACCEPT) && (key_q != KEY_ACCEPT);
    assign frame_tick = vblnk && !vblnk_q;

    assign zone_trigger = (current_pix == ZoneNpc1) || (current_pix == ZoneNpc2) ||
                          (current_pix == ZoneDoor) || (current_pix == ZoneItem);
    assign zone_left    = (current_pix != zone_q);

    // Only the NPC1 dialog has a second page.
    assign last_page = (sel_q == SelNpc1) ? 2'd1 : 2'd0;

    // Widened so a step past the page size cannot wrap before the clamp.
    assign reveal_sum = {1'b0, reveal_q} + RevealStep9;

`ifndef GAME_DIALOG_TYPEWRITER_EN
    logic unused_typewriter;
    assign unused_typewriter = ^{frame_tick, reveal_sum};
`endif

    always_comb begin
        state_d  = state_q;
        zone_d   = zone_q;
        sel_d    = sel_q;
        page_d   = page_q;
        reveal_d = reveal_q;
        on_d     = on_q;
        item_d   = item_q;
        item2_d  = item2_q;
        door_d   = door_q;

        unique case (state_q)
            StIdle: begin
                sel_d    = SelNone;
                page_d   = 2'd0;
                reveal_d = 8'd0;
                on_d     = 1'b0;
                if (zone_trigger) begin
                    state_d = StType;
                    zone_d  = current_pix;
                    on_d    = 1'b1;
                    if (current_pix == ZoneNpc1) begin
                        sel_d = SelNpc1;
                    end else if (current_pix == ZoneNpc2) begin
                        sel_d = item_q ? SelNpc2Post : SelNpc2Pre;
                    end else if (current_pix == ZoneDoor) begin
                        sel_d = door_q ? SelDoorOpen : SelDoorLocked;
                    end else begin
                        sel_d = SelItem;
                    end
                end
            end

            StType: begin
                if (zone_left) begin
                    // Walking away abandons the dialog with no action.
                    state_d  = StIdle;
                    sel_d    = SelNone;
                    page_d   = 2'd0;
                    reveal_d = 8'd0;
                    on_d     = 1'b0;
                end else begin
`ifdef GAME_DIALOG_TYPEWRITER_EN
                    if (key_press) begin
                        // Skip to the full page; this press is not an accept.
                        reveal_d = RevealFull;
                        state_d  = StFull;
                    end else if (frame_tick) begin
                        if (reveal_sum >= RevealFull9) begin
                            reveal_d = RevealFull;
                            state_d  = StFull;
                        end else begin
                            reveal_d = reveal_sum[7:0];
                        end
                    end
`else
                    reveal_d = RevealFull;
                    state_d  = StFull;
`endif
                end
            end

            StFull: begin
                if (zone_left) begin
                    state_d  = StIdle;
                    sel_d    = SelNone;
                    page_d   = 2'd0;
                    reveal_d = 8'd0;
                    on_d     = 1'b0;
                end else if (key_press) begin
                    if (page_q < last_page) begin
                        page_d   = page_q + 2'd1;
                        reveal_d = 8'd0;
                        state_d  = StType;
                    end else begin
                        // Final accept: apply the dialog's consequence.
                        if (sel_q == SelNpc2Pre) begin
                            item_d = 1'b1;
                        end
                        if ((sel_q == SelDoorLocked) && item_q) begin
                            door_d = 1'b1;
                        end
                        if ((sel_q == SelItem) && item_q) begin
                            item2_d = 1'b1;
                        end
                        state_d  = StDone;
                        sel_d    = SelNone;
                        page_d   = 2'd0;
                        reveal_d = 8'd0;
                        on_d     = 1'b0;
                    end
                end
            end

            StDone: begin
                sel_d    = SelNone;
                page_d   = 2'd0;
                reveal_d = 8'd0;
                on_d     = 1'b0;
                // Must step off the zone before it can trigger again.
                if (zone_left) begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d  = StIdle;
                sel_d    = SelNone;
                page_d   = 2'd0;
                reveal_d = 8'd0;
                on_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            zone_q   <= 4'd0;
            key_q    <= 4'd0;
            vblnk_q  <= 1'b0;
            sel_q    <= SelNone;
            page_q   <= 2'd0;
            reveal_q <= 8'd0;
            on_q     <= 1'b0;
            item_q   <= 1'b0;
            item2_q  <= 1'b0;
            door_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            zone_q   <= zone_d;
            key_q    <= key;
            vblnk_q  <= vblnk;
            sel_q    <= sel_d;
            page_q   <= page_d;
            reveal_q <= reveal_d;
            on_q     <= on_d;
            item_q   <= item_d;
            item2_q  <= item2_d;
            door_q   <= door_d;
        end
    end

    assign dialog_sel = sel_q;
    assign page       = page_q;
    assign reveal_cnt = reveal_q;
    assign dialog_on  = on_q;
    assign item       = item_q;
    assign item2      = item2_q;
    assign door       = door_q;

endmodule

// File: tb/tb_game_dialog_ctl.sv
// ----------------------------------------------------------------------------
// tb_game_dialog_ctl
//
// Directed bench for game_dialog_ctl. Inputs change 1 time unit after the
// rising edge; outputs are sampled at the same point. The typewriter sections
// follow GAME_DIALOG_TYPEWRITER_EN so both builds are covered.
// ----------------------------------------------------------------------------
module tb_game_dialog_ctl;

    logic       clk;
    logic       rst;
    logic [3:0] key;
    logic [3:0] current_pix;
    logic       vblnk;
    logic [2:0] dialog_sel;
    logic [1:0] page;
    logic [7:0] reveal_cnt;
    logic       dialog_on;
    logic       item;
    logic       item2;
    logic       door;

    int n_vec;
    int n_bad;

    game_dialog_ctl dut (
        .clk         (clk),
        .rst         (rst),
        .key         (key),
        .current_pix (current_pix),
        .vblnk       (vblnk),
        .dialog_sel  (dialog_sel),
        .page        (page),
        .reveal_cnt  (reveal_cnt),
        .dialog_on   (dialog_on),
        .item        (item),
        .item2       (item2),
        .door        (door)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic on, input logic [2:0] sel,
                           input logic [1:0] pg, input logic [7:0] rev);
        chk({tag, ".on"}, {8'd0, dialog_on}, {8'd0, on});
        chk({tag, ".sel"}, {6'd0, dialog_sel}, {6'd0, sel});
        chk({tag, ".page"}, {7'd0, page}, {7'd0, pg});
        chk({tag, ".reveal"}, {1'b0, reveal_cnt}, {1'b0, rev});
    endtask

    task automatic chk_flags(input string tag, input logic it, input logic it2,
                             input logic dr);
        chk({tag, ".item"}, {8'd0, item}, {8'd0, it});
        chk({tag, ".item2"}, {8'd0, item2}, {8'd0, it2});
        chk({tag, ".door"}, {8'd0, door}, {8'd0, dr});
    endtask

    // From TYPE to FULL with the page fully revealed and the key released.
    task automatic reach_full();
`ifdef GAME_DIALOG_TYPEWRITER_EN
        key = 4'h1;
        step();
        key = 4'h0;
        step();
`else
        step();
        step();
`endif
    endtask

    initial begin
        n_vec       = 0;
        n_bad       = 0;
        rst         = 1'b1;
        key         = 4'h0;
        current_pix = 4'd0;
        vblnk       = 1'b0;

        // Reset state
        step();
        step();
        chk_out("reset", 1'b0, 3'd0, 2'd0, 8'd0);
        chk_flags("reset", 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        step();
        chk_out("idle", 1'b0, 3'd0, 2'd0, 8'd0);

        // NPC1: two pages, no flag change
        current_pix = 4'd2;
        step();
        chk_out("npc1.entry", 1'b1, 3'd1, 2'd0, 8'd0);
`ifdef GAME_DIALOG_TYPEWRITER_EN
        for (int i = 1; i <= 64; i++) begin
            vblnk = 1'b1;
            step();
            chk("npc1.tw", {1'b0, reveal_cnt}, 9'(2 * i));
            vblnk = 1'b0;
            step();
        end
        for (int i = 0; i < 3; i++) begin
            vblnk = 1'b1;
            step();
            vblnk = 1'b0;
            step();
        end
        chk_out("npc1.sat", 1'b1, 3'd1, 2'd0, 8'd128);
        key = 4'h1;
        step();
        chk_out("npc1.page1", 1'b1, 3'd1, 2'd1, 8'd0);
        key = 4'h0;
        for (int i = 0; i < 10; i++) begin
            vblnk = 1'b1;
            step();
            vblnk = 1'b0;
            step();
        end
        chk_out("npc1.tw10", 1'b1, 3'd1, 2'd1, 8'd20);
        key = 4'h1;
        vblnk = 1'b1;
        step();
        chk_out("npc1.skip", 1'b1, 3'd1, 2'd1, 8'd128);
        key = 4'h0;
        vblnk = 1'b0;
        step();
`else
        step();
        chk_out("npc1.full", 1'b1, 3'd1, 2'd0, 8'd128);
        for (int i = 0; i < 3; i++) begin
            vblnk = 1'b1;
            step();
            vblnk = 1'b0;
            step();
        end
        chk_out("npc1.ticks_ignored", 1'b1, 3'd1, 2'd0, 8'd128);
        key = 4'h1;
        step();
        chk_out("npc1.page1", 1'b1, 3'd1, 2'd1, 8'd0);
        key = 4'h0;
        step();
        chk_out("npc1.page1_full", 1'b1, 3'd1, 2'd1, 8'd128);
`endif
        key = 4'h1;
        step();
        chk_out("npc1.done", 1'b0, 3'd0, 2'd0, 8'd0);
        chk_flags("npc1.done", 1'b0, 1'b0, 1'b0);
        repeat (20) step();
        key = 4'h0;
        repeat (3) step();
        chk_out("npc1.no_retrigger", 1'b0, 3'd0, 2'd0, 8'd0);
        current_pix = 4'd0;
        step();
        chk_out("npc1.idle", 1'b0, 3'd0, 2'd0, 8'd0);

        // Door while item=0: closes without opening
        current_pix = 4'd4;
        step();
        chk_out("door_locked.entry", 1'b1, 3'd4, 2'd0, 8'd0);
        reach_full();
        key = 4'h1;
        step();
        chk_out("door_locked.done", 1'b0, 3'd0, 2'd0, 8'd0);
        chk_flags("door_locked.done", 1'b0, 1'b0, 1'b0);
        key = 4'h0;
        current_pix = 4'd0;
        step();

        // NPC2 before item: grants item; held key does nothing more
        current_pix = 4'd3;
        step();
        chk_out("npc2.entry", 1'b1, 3'd2, 2'd0, 8'd0);
        reach_full();
        chk_out("npc2.full", 1'b1, 3'd2, 2'd0, 8'd128);
        key = 4'h1;
        step();
        chk_flags("npc2.accept", 1'b1, 1'b0, 1'b0);
        repeat (100) step();
        chk_out("npc2.held", 1'b0, 3'd0, 2'd0, 8'd0);
        chk_flags("npc2.held", 1'b1, 1'b0, 1'b0);
        key = 4'h0;
        current_pix = 4'd0;
        step();
        current_pix = 4'd3;
        step();
        chk_out("npc2.post", 1'b1, 3'd3, 2'd0, 8'd0);
        // Leave mid-TYPE: abort, outputs cleared
        current_pix = 4'd0;
        step();
        chk_out("npc2.abort", 1'b0, 3'd0, 2'd0, 8'd0);

        // Door with item=1: opens; re-entry shows the open text
        current_pix = 4'd4;
        step();
        chk_out("door.entry", 1'b1, 3'd4, 2'd0, 8'd0);
        reach_full();
        key = 4'h1;
        step();
        chk_flags("door.open", 1'b1, 1'b0, 1'b1);
        key = 4'h0;
        current_pix = 4'd0;
        step();
        current_pix = 4'd4;
        step();
        chk_out("door.reenter", 1'b1, 3'd5, 2'd0, 8'd0);
        reach_full();
        key = 4'h1;
        step();
        chk_out("door.open_done", 1'b0, 3'd0, 2'd0, 8'd0);
        key = 4'h0;
        current_pix = 4'd0;
        step();

        // Item zone abandoned before accept
        current_pix = 4'd6;
        step();
        chk_out("item.entry", 1'b1, 3'd6, 2'd0, 8'd0);
        current_pix = 4'd0;
        step();
        chk_out("item.abort", 1'b0, 3'd0, 2'd0, 8'd0);
        chk_flags("item.abort", 1'b1, 1'b0, 1'b1);

        // Direct switch between trigger zones while FULL
        current_pix = 4'd6;
        step();
        reach_full();
        chk_out("switch.full", 1'b1, 3'd6, 2'd0, 8'd128);
        current_pix = 4'd2;
        step();
        chk_out("switch.idle", 1'b0, 3'd0, 2'd0, 8'd0);
        step();
        chk_out("switch.reenter", 1'b1, 3'd1, 2'd0, 8'd0);
        current_pix = 4'd6;
        step();
        step();
        chk_out("switch.item", 1'b1, 3'd6, 2'd0, 8'd0);
        reach_full();
        key = 4'h1;
        step();
        chk_flags("item.accept", 1'b1, 1'b1, 1'b1);
        key = 4'h0;
        current_pix = 4'd0;
        step();

        // Asynchronous reset in the middle of a FULL page
        current_pix = 4'd2;
        step();
        reach_full();
        chk_out("rst.pre", 1'b1, 3'd1, 2'd0, 8'd128);
        #2;
        rst = 1'b1;
        #1;
        chk_out("rst.async", 1'b0, 3'd0, 2'd0, 8'd0);
        chk_flags("rst.async", 1'b0, 1'b0, 1'b0);
        current_pix = 4'd0;
        step();
        rst = 1'b0;
        step();
        chk_out("rst.idle", 1'b0, 3'd0, 2'd0, 8'd0);
        current_pix = 4'd3;
        step();
        chk_out("rst.reentry", 1'b1, 3'd2, 2'd0, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
